// File: rtl/optic_flow_pkg.sv
// Shared types and constants for the optic-flow code custom instruction.
package optic_flow_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } flow_state_e;

  localparam int unsigned FLOW_CODE_W       = 4;
  localparam int unsigned PIXELS_PER_WORD   = 4;
  localparam logic [7:0]  DEFAULT_THRESHOLD = 8'd16;
  localparam int unsigned MAG_SHIFT         = 5;

  // Width of the packed code field produced by one compute call.
  localparam int unsigned CODES_W = FLOW_CODE_W * PIXELS_PER_WORD;

endpackage

// File: rtl/optic_flow_code_ci_if.sv
// Custom-instruction handshake bundle: request operands in, completion pulse and result out.
interface optic_flow_code_ci_if;

  logic        start;
  logic [7:0]  ciN;
  logic [31:0] valueA;
  logic [31:0] valueB;
  logic        done;
  logic [31:0] result;

  // CPU side issues requests.
  modport master (
    output start, ciN, valueA, valueB,
    input  done, result
  );

  // Instruction unit side.
  modport slave (
    input  start, ciN, valueA, valueB,
    output done, result
  );

endinterface

// File: rtl/optic_flow_pixel_coder.sv
// Combinational 4-bit flow code for one pixel: {negative, magnitude class} or 0 below threshold.
module optic_flow_pixel_coder
  import optic_flow_pkg::*;
(
  input  logic [7:0]             cur,
  input  logic [7:0]             prev,
  input  logic [7:0]             threshold,
  output logic [FLOW_CODE_W-1:0] code
);

  logic [8:0] diff;
  logic       neg;
  logic [8:0] mag_wide;
  logic [7:0] mag;
  logic [7:0] mag_shifted;
  logic [2:0] mag_class;

  // Signed difference, absolute value with saturation, and magnitude class.
  always_comb begin
    diff        = {1'b0, cur} - {1'b0, prev};
    neg         = diff[8];
    mag_wide    = neg ? (9'd0 - diff) : diff;
    // |-256| cannot occur with 8-bit pixels, but keep the clamp explicit.
    mag         = mag_wide[8] ? 8'hff : mag_wide[7:0];
    mag_shifted = mag >> MAG_SHIFT;
    mag_class   = (mag_shifted > 8'd7) ? 3'd7 : mag_shifted[2:0];
    if (mag < threshold) begin
      code = '0;
    end else begin
      code = {neg, mag_class};
    end
  end

endmodule

// File: rtl/optic_flow_code_ci.sv
// Multi-cycle custom instruction: four pixel flow codes per call, packed with the previous call's
// codes into one 32-bit word for the colour mapper.
module optic_flow_code_ci
  import optic_flow_pkg::*;
#(
  parameter logic [7:0] customInstructionId = 8'd29,
  parameter logic [7:0] configInstructionId = 8'd31
) (
  input  logic                 clock,
  input  logic                 nReset,
  optic_flow_code_ci_if.slave  bus
);

  flow_state_e  state_q, state_d;
  logic [1:0]   idx_q;
  logic [31:0]  cur_q;
  logic [31:0]  prev_q;
  logic [7:0]   threshold_q;
  logic [CODES_W-1:0] history_q;
  logic [CODES_W-1:0] new_codes_q;
  logic         is_config_q;
  logic         done_q;
  logic [31:0]  result_q;

  logic         accept_calc;
  logic         accept_config;
  logic [7:0]   cur_pix;
  logic [7:0]   prev_pix;
  logic [FLOW_CODE_W-1:0] pix_code;

  // Select the pixel pair for the current index.
  always_comb begin
    cur_pix  = cur_q[{idx_q, 3'b000} +: 8];
    prev_pix = prev_q[{idx_q, 3'b000} +: 8];
  end

  optic_flow_pixel_coder u_pixel_coder (
    .cur       (cur_pix),
    .prev      (prev_pix),
    .threshold (threshold_q),
    .code      (pix_code)
  );

  // Next-state logic; requests are only accepted while idle.
  always_comb begin
    state_d       = state_q;
    accept_calc   = 1'b0;
    accept_config = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start && (bus.ciN == customInstructionId)) begin
          accept_calc = 1'b1;
          state_d     = StCalc;
        end else if (bus.start && (bus.ciN == configInstructionId)) begin
          accept_config = 1'b1;
          state_d       = StDone;
        end
      end
      StCalc: begin
        if (idx_q == 2'd3) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latches, configuration, per-pixel code accumulation and registered outputs.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      idx_q       <= 2'd0;
      cur_q       <= '0;
      prev_q      <= '0;
      threshold_q <= DEFAULT_THRESHOLD;
      history_q   <= '0;
      new_codes_q <= '0;
      is_config_q <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      if (accept_calc) begin
        cur_q       <= bus.valueA;
        prev_q      <= bus.valueB;
        idx_q       <= 2'd0;
        is_config_q <= 1'b0;
      end
      if (accept_config) begin
        threshold_q <= bus.valueA[7:0];
        history_q   <= '0;
        is_config_q <= 1'b1;
      end
      if (state_q == StCalc) begin
        new_codes_q[{idx_q, 2'b00} +: FLOW_CODE_W] <= pix_code;
        idx_q <= idx_q + 2'd1;
      end
      done_q <= (state_q == StDone);
      // Result is forced to zero outside the done cycle.
      if ((state_q == StDone) && !is_config_q) begin
        result_q  <= {new_codes_q, history_q};
        history_q <= new_codes_q;
      end else begin
        result_q <= '0;
      end
    end
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_optic_flow_code_ci.sv
// Directed bench for optic_flow_code_ci with hand-computed expected results.
module tb_optic_flow_code_ci;

  localparam logic [7:0] CI_CALC = 8'd29;
  localparam logic [7:0] CI_CFG  = 8'd31;

  logic clock;
  logic nReset;
  int   checks;
  int   errors;

  optic_flow_code_ci_if bus ();

  optic_flow_code_ci #(
    .customInstructionId (8'd29),
    .configInstructionId (8'd31)
  ) dut (
    .clock  (clock),
    .nReset (nReset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one call and wait (bounded) for done; lat is the edge count after the start edge.
  task automatic do_call(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output logic pulse_ok);
    @(negedge clock);
    bus.start  = 1'b1;
    bus.ciN    = id;
    bus.valueA = a;
    bus.valueB = b;
    @(negedge clock);
    bus.start = 1'b0;
    lat = -1;
    res = 32'hxxxx_xxxx;
    pulse_ok = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (bus.done === 1'b1) begin
        lat = i - 1;
        res = bus.result;
        break;
      end
      @(negedge clock);
    end
    if (lat >= 0) begin
      @(negedge clock);
      pulse_ok = (bus.done === 1'b0) && (bus.result === 32'h0);
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    logic        pok;
    int          dones;
    logic [31:0] cap;

    checks = 0;
    errors = 0;
    nReset = 1'b0;
    bus.start  = 1'b0;
    bus.ciN    = 8'd0;
    bus.valueA = 32'h0;
    bus.valueB = 32'h0;

    // 1. Reset defaults.
    repeat (3) @(negedge clock);
    nReset = 1'b1;
    @(negedge clock);
    check("reset_done", {31'd0, bus.done}, 32'h0);
    check("reset_result", bus.result, 32'h0);
    do_call(CI_CALC, 32'h0000_0010, 32'h0000_0000, lat, res, pok);
    check("thr_default_lat", lat, 32'd5);
    check("thr_default_result", res, 32'h0000_0000);
    check("thr_default_pulse", {31'd0, pok}, 32'h1);

    // 2. First compute.
    do_call(CI_CALC, 32'hFF50_1080, 32'h0048_9040, lat, res, pok);
    check("first_lat", lat, 32'd5);
    check("first_result", res, 32'h70C2_0000);
    check("first_pulse", {31'd0, pok}, 32'h1);

    // 3. History packing.
    do_call(CI_CALC, 32'hFF50_1080, 32'h0048_9040, lat, res, pok);
    check("hist_lat", lat, 32'd5);
    check("hist_result", res, 32'h70C2_70C2);
    check("hist_pulse", {31'd0, pok}, 32'h1);

    // 4. Config threshold 0, then d = -1 codes as 8.
    do_call(CI_CFG, 32'h0000_0000, 32'hDEAD_BEEF, lat, res, pok);
    check("cfg_lat", lat, 32'd1);
    check("cfg_result", res, 32'h0);
    check("cfg_pulse", {31'd0, pok}, 32'h1);
    do_call(CI_CALC, 32'h0000_0000, 32'h0000_0001, lat, res, pok);
    check("thr0_lat", lat, 32'd5);
    check("thr0_result", res, 32'h0008_0000);
    check("thr0_pulse", {31'd0, pok}, 32'h1);

    // 5a. Non-matching id produces no done.
    @(negedge clock);
    bus.start = 1'b1;
    bus.ciN   = 8'd47;
    @(negedge clock);
    bus.start = 1'b0;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clock);
    end
    check("bad_id_dones", dones, 32'd0);

    // 5b. Start during CALC is ignored.
    @(negedge clock);
    bus.start  = 1'b1;
    bus.ciN    = CI_CALC;
    bus.valueA = 32'hFF50_1080;
    bus.valueB = 32'h0048_9040;
    @(negedge clock);
    bus.start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    bus.start  = 1'b1;
    bus.valueA = 32'h0000_0000;
    bus.valueB = 32'hFFFF_FFFF;
    @(negedge clock);
    bus.start = 1'b0;
    dones = 0;
    cap   = 32'h0;
    for (int i = 0; i < 15; i++) begin
      if (bus.done === 1'b1) begin
        dones++;
        cap = bus.result;
      end
      @(negedge clock);
    end
    check("busy_dones", dones, 32'd1);
    check("busy_result", cap, 32'h70C2_0008);

    // 6. Reset mid-call: no done, history and threshold back to defaults.
    @(negedge clock);
    bus.start  = 1'b1;
    bus.ciN    = CI_CALC;
    bus.valueA = 32'hFF50_1080;
    bus.valueB = 32'h0048_9040;
    @(negedge clock);
    bus.start = 1'b0;
    dones = 0;
    @(negedge clock);
    nReset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clock);
    end
    nReset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (bus.done === 1'b1) dones++;
      @(negedge clock);
    end
    check("midreset_dones", dones, 32'd0);
    do_call(CI_CALC, 32'hFF50_1080, 32'h0048_9040, lat, res, pok);
    check("post_reset_lat", lat, 32'd5);
    check("post_reset_result", res, 32'h70C2_0000);
    check("post_reset_pulse", {31'd0, pok}, 32'h1);
    // d = -8 is below the default threshold of 16.
    do_call(CI_CALC, 32'h0000_0000, 32'h0000_0008, lat, res, pok);
    check("post_reset_thr_lat", lat, 32'd5);
    check("post_reset_thr_result", res, 32'h0000_70C2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
